// File: rtl/pipe_dmem_io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_dmem_io_pkg : address-map and register-field constants for data mem/IO
// Revision: 1.0
// ---------------------------------------------------------------------------
package pipe_dmem_io_pkg;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_IO  = 4'hF;

  localparam logic [2:0] IO_LED   = 3'd0;
  localparam logic [2:0] IO_SW    = 3'd1;
  localparam logic [2:0] IO_TCNT  = 3'd2;
  localparam logic [2:0] IO_TCMP  = 3'd3;
  localparam logic [2:0] IO_TCTRL = 3'd4;
  localparam logic [2:0] IO_TSTAT = 3'd5;

  localparam int TCTRL_EN    = 0;
  localparam int TCTRL_AR    = 1;
  localparam int TCTRL_IRQEN = 2;

endpackage

`default_nettype wire

// File: rtl/pipe_io_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_io_timer : 32-bit compare timer with sticky match flag and level irq
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_io_timer
  import pipe_dmem_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tcnt_o,
  output logic [31:0] tcmp_o,
  output logic [2:0]  tctrl_o,
  output logic        match_o,
  output logic        irq_o
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [2:0]  tctrl_q, tctrl_d;
  logic        match_q, match_d;
  logic        wr_tcnt;
  logic        hit;

  assign wr_tcnt = we_i && (sel_i == IO_TCNT);
  // A CPU write to TCNT suppresses match evaluation for that cycle.
  assign hit     = tctrl_q[TCTRL_EN] && (tcnt_q == tcmp_q) && !wr_tcnt;

  always_comb begin
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    match_d = match_q;

    if (wr_tcnt) begin
      tcnt_d = wdata_i;
    end else if (tctrl_q[TCTRL_EN]) begin
      tcnt_d = (hit && tctrl_q[TCTRL_AR]) ? 32'd0 : tcnt_q + 32'd1;
    end

    if (we_i && (sel_i == IO_TCMP))  tcmp_d  = wdata_i;
    if (we_i && (sel_i == IO_TCTRL)) tctrl_d = wdata_i[2:0];

    if (hit) begin
      match_d = 1'b1;
    end else if (we_i && (sel_i == IO_TSTAT) && wdata_i[0]) begin
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q  <= 32'd0;
      tcmp_q  <= 32'hFFFF_FFFF;
      tctrl_q <= 3'd0;
      match_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
      match_q <= match_d;
    end
  end

  assign tcnt_o  = tcnt_q;
  assign tcmp_o  = tcmp_q;
  assign tctrl_o = tctrl_q;
  assign match_o = match_q;
  assign irq_o   = match_q & tctrl_q[TCTRL_IRQEN];

endmodule

`default_nettype wire

// File: rtl/pipe_dmem_io.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_dmem_io : MEM-stage data RAM plus memory-mapped LED/switch/timer block
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipe_dmem_io
  import pipe_dmem_io_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int SW_W       = 16,
  parameter int LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_w,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]      mem_q [DMEM_WORDS];
  logic [AW-1:0]    ram_idx;
  logic             ram_hit;
  logic             io_hit;
  logic [2:0]       io_sel;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [31:0]      tcnt, tcmp;
  logic [2:0]       tctrl;
  logic             match;
  logic             unused_addr;

  assign unused_addr = ^addr[1:0];
  assign ram_idx     = addr[AW+1:2];
  assign ram_hit     = (addr[31:28] == REGION_RAM);
  assign io_hit      = (addr[31:28] == REGION_IO) && (addr[27:5] == 23'd0);
  assign io_sel      = addr[4:2];

  always_ff @(posedge clk) begin
    if (!rst && mem_w && ram_hit) mem_q[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (mem_w && io_hit && (io_sel == IO_LED)) led_q <= wdata[LED_W-1:0];
    end
  end

  pipe_io_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_w && io_hit),
    .sel_i   (io_sel),
    .wdata_i (wdata),
    .tcnt_o  (tcnt),
    .tcmp_o  (tcmp),
    .tctrl_o (tctrl),
    .match_o (match),
    .irq_o   (irq)
  );

  always_comb begin
    rdata = 32'd0;
    if (ram_hit) begin
      rdata = mem_q[ram_idx];
    end else if (io_hit) begin
      case (io_sel)
        IO_LED:   rdata = 32'(led_q);
        IO_SW:    rdata = 32'(sw_sync_q);
        IO_TCNT:  rdata = tcnt;
        IO_TCMP:  rdata = tcmp;
        IO_TCTRL: rdata = {29'd0, tctrl};
        IO_TSTAT: rdata = {31'd0, match};
        default:  rdata = 32'd0;
      endcase
    end
  end

  assign led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_dmem_io.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_dmem_io : directed self-checking bench for pipe_dmem_io
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipe_dmem_io;

  localparam logic [31:0] A_LED   = 32'hF000_0000;
  localparam logic [31:0] A_SW    = 32'hF000_0004;
  localparam logic [31:0] A_TCNT  = 32'hF000_0008;
  localparam logic [31:0] A_TCMP  = 32'hF000_000C;
  localparam logic [31:0] A_TCTRL = 32'hF000_0010;
  localparam logic [31:0] A_TSTAT = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [15:0] sw = 16'd0;
  logic [15:0] led;
  logic        irq;

  int total = 0;
  int bad   = 0;

  pipe_dmem_io dut (
    .clk   (clk),
    .rst   (rst),
    .mem_w (mem_w),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .sw    (sw),
    .led   (led),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    mem_w = 1'b1;
    @(posedge clk);
    #1;
    mem_w = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    step(2);
    rst = 1'b0;

    // Reset state
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd("rst_tcnt", A_TCNT, 32'd0);

    // RAM store/load, byte offset ignored, aliasing, unmapped
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_rd_off3", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
    rd("unmapped_hi", 32'h8000_0000, 32'd0);
    rd("unmapped_io", 32'hF000_0020, 32'd0);
    rd("unmapped_sel6", 32'hF000_0018, 32'd0);

    // Same-cycle write and read shows the old value
    wr(32'h0000_0020, 32'hCAFE_F00D);
    addr = 32'h0000_0020; wdata = 32'h0BAD_C0DE; mem_w = 1'b1;
    #1;
    chk("ram_rw_old", rdata, 32'hCAFE_F00D);
    @(posedge clk); #1; mem_w = 1'b0;
    rd("ram_rw_new", 32'h0000_0020, 32'h0BAD_C0DE);

    // LED and switch synchroniser
    wr(A_LED, 32'h1234_A5A5);
    chk("led_pin", {16'd0, led}, 32'h0000_A5A5);
    rd("led_rd", A_LED, 32'h0000_A5A5);
    sw = 16'h00FF;
    rd("sw_0edge", A_SW, 32'd0);
    step(1);
    rd("sw_1edge", A_SW, 32'd0);
    step(1);
    rd("sw_2edge", A_SW, 32'h0000_00FF);

    // Timer one-shot with irq
    wr(A_TCMP, 32'd5);
    wr(A_TCTRL, 32'h5);
    rd("os_tcnt0", A_TCNT, 32'd0);
    rd("os_tctrl", A_TCTRL, 32'h5);
    step(5);
    rd("os_tcnt5", A_TCNT, 32'd5);
    rd("os_nomatch", A_TSTAT, 32'd0);
    chk("os_irq_lo", {31'd0, irq}, 32'd0);
    step(1);
    rd("os_match", A_TSTAT, 32'd1);
    chk("os_irq_hi", {31'd0, irq}, 32'd1);
    rd("os_tcnt6", A_TCNT, 32'd6);
    step(1);
    rd("os_tcnt7", A_TCNT, 32'd7);
    wr(A_TSTAT, 32'h1);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);
    rd("os_match_clr", A_TSTAT, 32'd0);

    // Autoreload, IRQEN off
    wr(A_TCTRL, 32'h0);
    wr(A_TCNT, 32'd0);
    wr(A_TSTAT, 32'h0);
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'h3);
    rd("ar_t0", A_TCNT, 32'd0);
    step(1); rd("ar_t1", A_TCNT, 32'd1);
    step(1); rd("ar_t2", A_TCNT, 32'd2);
    step(1); rd("ar_t3", A_TCNT, 32'd3);
    rd("ar_nomatch", A_TSTAT, 32'd0);
    step(1); rd("ar_wrap", A_TCNT, 32'd0);
    rd("ar_match", A_TSTAT, 32'd1);
    chk("ar_irq", {31'd0, irq}, 32'd0);
    step(1); rd("ar_t1b", A_TCNT, 32'd1);

    // Collisions: W1C vs new match, CPU write vs reload
    wr(A_TSTAT, 32'h1);
    rd("col_pre_clr", A_TSTAT, 32'd0);
    rd("col_pre_t2", A_TCNT, 32'd2);
    step(1);
    wr(A_TSTAT, 32'h1);
    rd("col_set_wins", A_TSTAT, 32'd1);
    rd("col_reload", A_TCNT, 32'd0);
    wr(A_TSTAT, 32'h1);
    rd("col_clr2", A_TSTAT, 32'd0);
    step(2);
    rd("col_t3", A_TCNT, 32'd3);
    wr(A_TCNT, 32'h100);
    rd("col_cpu_wins", A_TCNT, 32'h100);
    rd("col_no_match", A_TSTAT, 32'd0);

    // Reset mid-operation
    wr(A_LED, 32'h0000_FFFF);
    wr(A_TCMP, 32'h108);
    wr(A_TCTRL, 32'h7);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      addr = A_TSTAT;
      #1;
      seen = rdata[0];
    end
    chk("pre_rst_match", {31'd0, seen}, 32'd1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    chk("pre_rst_led", {16'd0, led}, 32'h0000_FFFF);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("post_rst_led", {16'd0, led}, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    rd("post_rst_tcnt", A_TCNT, 32'd0);
    rd("post_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd("post_rst_tctrl", A_TCTRL, 32'd0);
    rd("post_rst_tstat", A_TSTAT, 32'd0);
    rd("post_rst_sw", A_SW, 32'd0);
    rd("post_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    step(1);
    rd("post_rst_hold", A_TCNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_dmem_io.md
Name: pipe_dmem_io

Overview:
Data-side memory and I/O block directly downstream of the pipelined CPU's MEM stage. It consumes the CPU's MemWrite, aluout (address) and writedata, and returns readdata in the same cycle. It decodes the address into one of two targets:
- word-addressed data RAM;
- a small memory-mapped peripheral set: LED register, synchronised switch input, and a 32-bit compare timer with a sticky match flag and an interrupt output.

Parameters:
DMEM_WORDS, 1024, data RAM depth in 32-bit words (power of two).
SW_W, 16, switch input width.
LED_W, 16, LED output width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
mem_w  input  1  store strobe from CPU MEM stage (MemWrite)
addr  input  32  byte address from CPU (aluout)
wdata  input  32  store data from CPU (writedata)
rdata  output  32  load data to CPU (readdata), combinational
sw  input  SW_W  asynchronous switch inputs
led  output  LED_W  LED register
irq  output  1  timer interrupt, level

Behaviour:
Address decode; addr[1:0] is ignored (word access only):
- addr[31:28]==4'h0: RAM, index addr[log2(DMEM_WORDS)+1:2], upper bits aliased.
- addr[31:28]==4'hF, addr[27:5]==0: I/O, register select addr[4:2]:
  - 0 LED (RW)
  - 1 SW (RO)
  - 2 TCNT (RW)
  - 3 TCMP (RW)
  - 4 TCTRL (RW): bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; bits 31:3 read 0
  - 5 TSTAT (W1C): bit0 MATCH
- Anything else is unmapped: reads return 0, writes ignored. Selects 6–7 are unmapped.

Reads:
- rdata is purely combinational from addr and current register/RAM contents, zero added latency. The CPU samples it in the same cycle.
- RAM read is asynchronous.
- LED reads zero-extended. SW reads the synchronised value, zero-extended.

Writes:
- Take effect at the clk edge where mem_w=1.
- A write and a read to the same location in one cycle: rdata shows the old value.
- RAM is written full-word.

Switch path:
- 2-flop synchroniser. A change on sw is visible on rdata at the 2nd rising edge after it settles.

Timer:
- When EN=1, TCNT increments by 1 every cycle and wraps 0xFFFFFFFF->0.
- When EN=1 and TCNT==TCMP at a clock edge:
  - MATCH is set;
  - if AUTORELOAD=1, next TCNT=0; otherwise it keeps incrementing.
- Comparison uses the pre-increment TCNT value.
- With EN=0, TCNT holds and no match is generated.

Write priorities:
- CPU write to TCNT in the same cycle as increment or reload: CPU write wins, no match evaluated that cycle.
- CPU W1C of MATCH in the same cycle a new match occurs: set wins.
- Writing 0 to TSTAT bit0 has no effect.

Interrupt:
- irq = MATCH & IRQEN, derived from registered state only (no combinational path from addr or wdata).

Reset (rst=1 at a clock edge):
- led=0, TCNT=0, TCMP=32'hFFFFFFFF, TCTRL=0, TSTAT=0, synchroniser flops=0, hence irq=0.
- RAM contents are not reset.
- rst has priority over any concurrent mem_w or timer event.

Decomposition:
- Shared package holds:
  - region nibble constants: REGION_RAM=4'h0, REGION_IO=4'hF;
  - I/O select constants: IO_LED=0, IO_SW=1, IO_TCNT=2, IO_TCMP=3, IO_TCTRL=4, IO_TSTAT=5;
  - TCTRL bit index constants.
- One sub-module is natural: pipe_io_timer. It contains TCNT, TCMP, TCTRL, TSTAT, match/reload logic and irq, and takes a local select, write strobe and wdata. The RAM and the decode/read mux stay in the top.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> rdata=0xDEADBEEF. Read 0x0000_0013 -> same value. Read unmapped 0x8000_0000 -> 0.
2. LED/SW: write 0x1234_A5A5 to 0xF000_0000 -> led=0xA5A5 next cycle; readback 0x0000_A5A5. Drive sw=0x00FF -> read of 0xF000_0004 returns 0 one edge later and 0x0000_00FF after the 2nd edge.
3. Timer one-shot: TCMP=5, TCTRL=0x5 (EN|IRQEN) -> MATCH and irq rise after the edge where TCNT==5. TCNT continues 6,7,… Write 1 to 0xF000_0014 -> irq low next cycle.
4. Autoreload: TCMP=3, TCTRL=0x3 -> TCNT sequence 0,1,2,3,0,1,… MATCH set on first wrap. irq stays 0 since IRQEN=0.
5. Collisions: W1C of MATCH in the cycle of a new match -> MATCH remains 1. CPU write TCNT=0x100 in a reload cycle -> TCNT=0x100.
6. Reset mid-operation: timer running with MATCH=1 and led=0xFFFF, assert rst for one edge -> all registers at reset values, irq=0. Previously written RAM word still reads back unchanged.
